cdd_sector_feeder: RTL and testbench



---
 rtl/cdd_sector_feeder.sv | 250 +++++++++++++++++++++++++
 tb/tb_cdd_sector_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdd_sector_feeder.sv
// -----------------------------------------------------------------------------
// cdd_sector_feeder
//
// Upstream stage of the CDC data receiver. The host MCU fills raw 2352-byte
// sectors into a two-bank ping-pong buffer; on each 75 Hz sector sync one full
// bank is replayed to the CDC at disc byte rate, one byte per dclk strobe.
//
// Ports
//   clk_asic     system clock
//   rst          asynchronous active-high reset
//   host_we      host byte write strobe into the current write bank
//   host_addr    host byte address within the sector
//   host_data    host write data
//   host_commit  one-clock pulse: current write bank is complete
//   flag_clr     clears the sticky flags (a same-cycle set wins)
//   dclk         one-clock CD byte-rate strobe
//   sector_sync  one-clock pulse at each sector boundary
//   cdc_we       high for the whole duration of a sector transfer
//   cdc_we_sync  one-clock strobe per delivered byte
//   cdc_addr     byte index of the current byte within the sector
//   cdc_dato     data byte for the current strobe
//   banks_full   per-bank full flags
//   host_ovf     sticky: commit arrived while both banks were full
//   underrun     sticky: sector_sync arrived with no full bank
//   overrun      sticky: sector_sync arrived during an active transfer or gap
//   sector_cnt   count of sectors delivered (wraps at 16 bits)
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for sector_sync; read address parked on byte 0
//   S_PRIME  | one clock covering the RAM read latency for byte 0
//   S_STREAM | one byte delivered per dclk; releases the bank at the end
//   S_GAP    | cdc_we held low for IDLE_GAP clocks between sectors
// -----------------------------------------------------------------------------
module cdd_sector_feeder #(
    parameter int SECTOR_LEN = 2352,
    parameter int ADDR_W     = 12,
    parameter int IDLE_GAP   = 2
) (
    input  logic              clk_asic,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_data,
    input  logic              host_commit,
    input  logic              flag_clr,
    input  logic              dclk,
    input  logic              sector_sync,
    output logic              cdc_we,
    output logic              cdc_we_sync,
    output logic [ADDR_W-1:0] cdc_addr,
    output logic [7:0]        cdc_dato,
    output logic [1:0]        banks_full,
    output logic              host_ovf,
    output logic              underrun,
    output logic              overrun,
    output logic [15:0]       sector_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(SECTOR_LEN);
    localparam int                GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              wb;
    logic              rb;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] rd_idx_nxt;
    logic [7:0]        ram_q;
    logic              dclk_pend;
    logic              last_sent;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        bf_nxt;

    logic              start;
    logic              under_set;
    logic              over_set;
    logic              take;
    logic              sector_done;
    logic              gap_done;
    logic              wr_en;
    logic              commit_ok;
    logic              commit_ovf;

    // -------------------------------------------------------------------------
    // Ping-pong sector buffer
    // -------------------------------------------------------------------------
    logic [7:0] mem [2][SECTOR_LEN];

    // A bank marked full is never written, so the bank being streamed (always
    // full until released) is safe from the host side.
    assign wr_en      = host_we && !banks_full[wb] && ({1'b0, host_addr} < LEN_EXT);
    assign commit_ok  = host_commit && !banks_full[wb];
    assign commit_ovf = host_commit && banks_full[wb];

    always_ff @(posedge clk_asic) begin
        if (wr_en) begin
            mem[wb][host_addr] <= host_data;
        end
    end

    // The read address register is the RAM's own input register, so the word
    // selected by rd_idx_nxt is available one clock later. This keeps the
    // prefetch register one byte ahead even when a pending dclk is serviced
    // on the first STREAM clock and the next dclk follows two clocks later.
    always_ff @(posedge clk_asic) begin
        ram_q <= mem[rb][rd_idx_nxt];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_asic or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start)       state_nxt = S_PRIME;
            S_PRIME:                   state_nxt = S_STREAM;
            S_STREAM: if (sector_done) state_nxt = S_GAP;
            S_GAP:    if (gap_done)    state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: decoded controls
    // -------------------------------------------------------------------------
    always_comb begin
        start       = (state == S_IDLE) && sector_sync && banks_full[rb];
        under_set   = (state == S_IDLE) && sector_sync && !banks_full[rb];
        over_set    = (state != S_IDLE) && sector_sync;
        take        = (state == S_STREAM) && !last_sent && (dclk || dclk_pend);
        // The release waits one clock after the last take so the final
        // cdc_we_sync strobe is still inside the cdc_we window.
        sector_done = (state == S_STREAM) && last_sent;
        gap_done    = (state == S_GAP) && (gap_cnt == '0);

        rd_idx_nxt = rd_idx;
        if (state == S_IDLE) begin
            rd_idx_nxt = '0;
        end else if (take) begin
            rd_idx_nxt = (rd_idx == LAST_IDX) ? '0 : rd_idx + ADDR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Bank bookkeeping: a release and a commit in the same clock both apply.
    // -------------------------------------------------------------------------
    always_comb begin
        bf_nxt = banks_full;
        if (sector_done) bf_nxt[rb] = 1'b0;
        if (commit_ok)   bf_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clk_asic or posedge rst) begin
        if (rst) begin
            banks_full <= 2'b00;
            wb         <= 1'b0;
            rb         <= 1'b0;
            sector_cnt <= 16'd0;
        end else begin
            banks_full <= bf_nxt;
            if (commit_ok)   wb <= ~wb;
            if (sector_done) begin
                rb         <= ~rb;
                sector_cnt <= sector_cnt + 16'd1;
            end
        end
    end

    // Sticky flags: a set in the same clock as flag_clr wins.
    always_ff @(posedge clk_asic or posedge rst) begin
        if (rst) begin
            host_ovf <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            host_ovf <= (host_ovf & ~flag_clr) | commit_ovf;
            underrun <= (underrun & ~flag_clr) | under_set;
            overrun  <= (overrun  & ~flag_clr) | over_set;
        end
    end

    // -------------------------------------------------------------------------
    // Streaming datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_asic or posedge rst) begin
        if (rst) begin
            rd_idx      <= '0;
            dclk_pend   <= 1'b0;
            last_sent   <= 1'b0;
            gap_cnt     <= '0;
            cdc_we      <= 1'b0;
            cdc_we_sync <= 1'b0;
            cdc_addr    <= '0;
            cdc_dato    <= 8'd0;
        end else begin
            rd_idx      <= rd_idx_nxt;
            cdc_we      <= (state_nxt == S_PRIME) || (state_nxt == S_STREAM);
            cdc_we_sync <= take;

            if (take) begin
                cdc_addr <= rd_idx;
                cdc_dato <= ram_q;
            end

            // A dclk landing in PRIME is remembered and served on the first
            // STREAM clock.
            if ((state == S_PRIME) && dclk) begin
                dclk_pend <= 1'b1;
            end else if (state == S_STREAM) begin
                dclk_pend <= 1'b0;
            end

            if (take && (rd_idx == LAST_IDX)) begin
                last_sent <= 1'b1;
            end else if (sector_done) begin
                last_sent <= 1'b0;
            end

            if (sector_done) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdd_sector_feeder.sv
// -----------------------------------------------------------------------------
// tb_cdd_sector_feeder
//
// Self-checking bench for cdd_sector_feeder. The reference model treats the
// buffer as a FIFO of committed sector images (a flat byte queue plus a count
// of full banks) and derives the flag and counter expectations from the
// host/sector events it issues.
// -----------------------------------------------------------------------------
module tb_cdd_sector_feeder;

    localparam int SECTOR_LEN = 2352;
    localparam int ADDR_W     = 12;

    logic              clk;
    logic              rst;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_data;
    logic              host_commit;
    logic              flag_clr;
    logic              dclk;
    logic              sector_sync;
    logic              cdc_we;
    logic              cdc_we_sync;
    logic [ADDR_W-1:0] cdc_addr;
    logic [7:0]        cdc_dato;
    logic [1:0]        banks_full;
    logic              host_ovf;
    logic              underrun;
    logic              overrun;
    logic [15:0]       sector_cnt;

    cdd_sector_feeder dut (
        .clk_asic    (clk),
        .rst         (rst),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_commit (host_commit),
        .flag_clr    (flag_clr),
        .dclk        (dclk),
        .sector_sync (sector_sync),
        .cdc_we      (cdc_we),
        .cdc_we_sync (cdc_we_sync),
        .cdc_addr    (cdc_addr),
        .cdc_dato    (cdc_dato),
        .banks_full  (banks_full),
        .host_ovf    (host_ovf),
        .underrun    (underrun),
        .overrun     (overrun),
        .sector_cnt  (sector_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [7:0] cur_img [SECTOR_LEN];
    logic [7:0] mdl_q [$];
    int         mdl_full;
    int         mdl_rb;
    int         mdl_cnt;
    logic       exp_ovf, exp_under, exp_over;

    // strobe capture
    logic [ADDR_W-1:0] got_a [$];
    logic [7:0]        got_d [$];
    int                env_bad;

    always @(negedge clk) begin
        if (!rst && cdc_we_sync === 1'b1) begin
            got_a.push_back(cdc_addr);
            got_d.push_back(cdc_dato);
            if (cdc_we !== 1'b1) env_bad++;
        end
    end

    typedef struct {
        logic       sync;
        logic       commit;
        logic       clr;
        logic [1:0] bf;
        logic       ovf;
        logic       under;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_bf();
        if (mdl_full == 0) return 2'b00;
        if (mdl_full >= 2) return 2'b11;
        return (mdl_rb == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        mdl_full  = 0;
        mdl_rb    = 0;
        mdl_cnt   = 0;
        exp_ovf   = 1'b0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_banks_full"}, banks_full, exp_bf());
        chk({tag, "_host_ovf"},   host_ovf,   exp_ovf);
        chk({tag, "_underrun"},   underrun,   exp_under);
        chk({tag, "_overrun"},    overrun,    exp_over);
        chk({tag, "_sector_cnt"}, sector_cnt, 16'(mdl_cnt));
    endtask

    // mode 0: byte = addr[7:0], mode 1: random, mode 2: 0xFF filler
    task automatic host_fill(input int mode);
        for (int a = 0; a < SECTOR_LEN; a++) begin
            host_we   = 1'b1;
            host_addr = ADDR_W'(a);
            case (mode)
                0:       host_data = 8'(a);
                1:       host_data = 8'($urandom);
                default: host_data = 8'hFF;
            endcase
            if (mdl_full < 2) cur_img[a] = host_data;
            @(negedge clk);
        end
        host_we = 1'b0;
    endtask

    task automatic do_commit();
        host_commit = 1'b1;
        if (mdl_full < 2) begin
            for (int a = 0; a < SECTOR_LEN; a++) mdl_q.push_back(cur_img[a]);
            mdl_full++;
        end else begin
            exp_ovf = 1'b1;
        end
        @(negedge clk);
        host_commit = 1'b0;
    endtask

    task automatic do_clr();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr  = 1'b0;
        exp_ovf   = 1'b0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
    endtask

    // Issues sector_sync and paces dclk every sp clocks until cdc_we falls.
    // sync_at >= 0: extra sector_sync once that many bytes have been seen.
    // gap_sync:     sector_sync on the second gap clock (must not start).
    // rst_at >= 0:  async reset once that many bytes have been seen.
    task automatic run_sector(input int sp, input int sync_at, input bit gap_sync,
                              input int rst_at);
        int k;
        int budget;
        int nerr_a;
        int nerr_d;
        int nstb;
        int highs;
        bit we_seen;
        bit done;
        bit synced;
        got_a.delete();
        got_d.delete();
        env_bad = 0;
        budget  = SECTOR_LEN * sp + 64;
        sector_sync = 1'b1;
        @(negedge clk);
        sector_sync = 1'b0;
        k = 0; we_seen = 0; done = 0; synced = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            dclk = ((k % sp) == 0);
            k++;
            if (sync_at >= 0 && !synced && got_d.size() >= sync_at) begin
                sector_sync = 1'b1;
                synced      = 1'b1;
            end
            if (rst_at >= 0 && got_d.size() >= rst_at) begin
                dclk        = 1'b0;
                sector_sync = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_cdc_we",     cdc_we,      0);
                chk("rst_mid_banks_full", banks_full,  0);
                chk("rst_mid_we_sync",    cdc_we_sync, 0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_status("post_rst");
                return;
            end
            @(negedge clk);
            sector_sync = 1'b0;
            dclk        = 1'b0;
            if (cdc_we) we_seen = 1;
            else if (we_seen) done = 1;
        end
        chk("stream_done", done, 1);

        // first gap clock observed; now the second one
        @(negedge clk);
        chk("gap_low_2nd", cdc_we, 0);
        if (gap_sync) begin
            sector_sync = 1'b1;
            exp_over    = 1'b1;
        end
        @(negedge clk);
        sector_sync = 1'b0;
        if (gap_sync) begin
            highs = 0;
            for (int i = 0; i < 6; i++) begin
                if (cdc_we !== 1'b0) highs++;
                @(negedge clk);
            end
            chk("gap_sync_not_queued", highs, 0);
        end

        nstb = got_d.size();
        chk("strobe_cnt", nstb, SECTOR_LEN);
        nerr_a = 0;
        nerr_d = 0;
        for (int n = 0; n < nstb && n < SECTOR_LEN; n++) begin
            if (got_a[n] !== ADDR_W'(n)) nerr_a++;
            if (n < mdl_q.size() && got_d[n] !== mdl_q[n]) nerr_d++;
        end
        chk("addr_seq_errs", nerr_a, 0);
        chk("data_seq_errs", nerr_d, 0);
        chk("we_envelope_errs", env_bad, 0);

        for (int n = 0; n < SECTOR_LEN && mdl_q.size() > 0; n++) void'(mdl_q.pop_front());
        if (mdl_full > 0) mdl_full--;
        mdl_rb  = 1 - mdl_rb;
        mdl_cnt = mdl_cnt + 1;
        if (sync_at >= 0) exp_over = 1'b1;
        check_status("after_sector");
    endtask

    initial begin
        int sp;
        int sa;

        rst = 1'b1;
        host_we = 1'b0; host_addr = '0; host_data = 8'd0; host_commit = 1'b0;
        flag_clr = 1'b0; dclk = 1'b0; sector_sync = 1'b0;
        model_reset();

        //           sync  commit clr   bf     ovf   under
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {cdc_we, cdc_we_sync, cdc_addr, cdc_dato, banks_full, host_ovf,
             underrun, overrun, sector_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_status("after_reset");

        // flag / bank bookkeeping vectors
        for (int i = 0; i < 11; i++) begin
            sector_sync = tbl[i].sync;
            host_commit = tbl[i].commit;
            flag_clr    = tbl[i].clr;
            @(negedge clk);
            sector_sync = 1'b0;
            host_commit = 1'b0;
            flag_clr    = 1'b0;
            chk($sformatf("tbl%0d", i),
                {banks_full, host_ovf, underrun, overrun, cdc_we},
                {tbl[i].bf, tbl[i].ovf, tbl[i].under, 1'b0, 1'b0});
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_status("tbl_reset");

        // addr-pattern sector, dclk every 2 clocks
        host_fill(0);
        do_commit();
        check_status("t1_commit");
        run_sector(2, -1, 1'b0, -1);

        // two banks, dropped writes, third commit, sync in gap
        host_fill(1);
        do_commit();
        host_fill(1);
        do_commit();
        host_fill(2);
        do_commit();
        check_status("t3_both_full");
        run_sector(2, -1, 1'b1, -1);
        do_clr();
        run_sector(3, -1, 1'b0, -1);
        do_clr();
        check_status("t3_clr");

        // sector_sync mid-transfer
        host_fill(1);
        do_commit();
        run_sector(2, 1000, 1'b0, -1);
        do_clr();
        check_status("t4_clr");

        // reset at byte 500, then a clean sector
        host_fill(1);
        do_commit();
        run_sector(2, -1, 1'b0, 500);
        host_fill(1);
        do_commit();
        run_sector(2, -1, 1'b0, -1);

        // randomized rounds
        for (int r = 0; r < 2; r++) begin
            sp = int'($urandom_range(4, 2));
            sa = ($urandom_range(1, 0) == 1) ? int'($urandom_range(2300, 5)) : -1;
            host_fill(1);
            do_commit();
            run_sector(sp, sa, 1'b0, -1);
            do_clr();
            check_status($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
